// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter: round-robin sequencer that shares the register_memory
// read/write ports between the pipeline core (C) and the debug unit (D).
// One transaction is in flight at a time; read data is captured one cycle
// after the addresses are presented (registered read in register_memory).
// Optional feature: define RF_XZR_EN to make register 31 a zero register
// (writes dropped but acknowledged, reads return zero per lane).
module regfile_port_arbiter #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              c_req_valid,
    output logic              c_req_ready,
    input  logic              c_req_write,
    input  logic [ADDR_W-1:0] c_req_addr1,
    input  logic [ADDR_W-1:0] c_req_addr2,
    input  logic [DATA_W-1:0] c_req_wdata,
    output logic              c_rsp_valid,
    input  logic              c_rsp_ready,

    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_req_write,
    input  logic [ADDR_W-1:0] d_req_addr1,
    input  logic [ADDR_W-1:0] d_req_addr2,
    input  logic [DATA_W-1:0] d_req_wdata,
    output logic              d_rsp_valid,
    input  logic              d_rsp_ready,

    output logic [DATA_W-1:0] rsp_data1,
    output logic [DATA_W-1:0] rsp_data2,

    output logic [ADDR_W-1:0] rf_read_reg1,
    output logic [ADDR_W-1:0] rf_read_reg2,
    output logic [ADDR_W-1:0] rf_write_reg,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_reg_write,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2
);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StCapture,
        StResp
    } state_e;

    localparam logic OwnC = 1'b0;
    localparam logic OwnD = 1'b1;

    state_e state_q, state_d;
    logic   last_grant_q;
    logic   cmd_write_q;
    logic   cmd_owner_q;

    logic              grant_c, grant_d;
    logic              accept;
    logic              owner_rsp_ready;
    logic              sel_write;
    logic              sel_commit;
    logic [ADDR_W-1:0] sel_addr1, sel_addr2;
    logic [DATA_W-1:0] sel_wdata;
    logic [DATA_W-1:0] rd1, rd2;

    // Round-robin grant: a lone requester wins, on contention the one not granted last time wins
    always_comb begin
        grant_c = c_req_valid && (!d_req_valid || (last_grant_q == OwnD));
        grant_d = d_req_valid && (!c_req_valid || (last_grant_q == OwnC));
    end

    // Ready only in IDLE; gated by reset_n so it stays low while reset is asserted
    assign c_req_ready = reset_n && (state_q == StIdle) && grant_c;
    assign d_req_ready = reset_n && (state_q == StIdle) && grant_d;
    assign accept      = c_req_ready || d_req_ready;

    assign owner_rsp_ready = (cmd_owner_q == OwnD) ? d_rsp_ready : c_rsp_ready;
    assign c_rsp_valid     = (state_q == StResp) && (cmd_owner_q == OwnC);
    assign d_rsp_valid     = (state_q == StResp) && (cmd_owner_q == OwnD);

    // Mux the request fields of the granted requester
    always_comb begin
        if (d_req_ready) begin
            sel_write = d_req_write;
            sel_addr1 = d_req_addr1;
            sel_addr2 = d_req_addr2;
            sel_wdata = d_req_wdata;
        end else begin
            sel_write = c_req_write;
            sel_addr1 = c_req_addr1;
            sel_addr2 = c_req_addr2;
            sel_wdata = c_req_wdata;
        end
    end

`ifdef RF_XZR_EN
    localparam logic [ADDR_W-1:0] XzrReg = ADDR_W'(31);
    // Writes to the zero register are acknowledged but never committed
    assign sel_commit = sel_write && (sel_addr1 != XzrReg);
    assign rd1 = (rf_read_reg1 == XzrReg) ? '0 : rf_read_data1;
    assign rd2 = (rf_read_reg2 == XzrReg) ? '0 : rf_read_data2;
`else
    assign sel_commit = sel_write;
    assign rd1 = rf_read_data1;
    assign rd2 = rf_read_data2;
`endif

    // Next-state logic for the transaction sequencer
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (accept) state_d = StAccess;
            StAccess:  state_d = cmd_write_q ? StResp : StCapture;
            StCapture: state_d = StResp;
            StResp:    if (owner_rsp_ready) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // State, arbitration history and command ownership
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            last_grant_q <= OwnD;
            cmd_write_q  <= 1'b0;
            cmd_owner_q  <= OwnC;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_grant_q <= d_req_ready ? OwnD : OwnC;
                cmd_write_q  <= sel_write;
                cmd_owner_q  <= d_req_ready ? OwnD : OwnC;
            end
        end
    end

    // rf_* registers double as the address/data command registers; loaded on accept so
    // they are valid during ACCESS and hold their value afterwards
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_read_reg1  <= '0;
            rf_read_reg2  <= '0;
            rf_write_reg  <= '0;
            rf_write_data <= '0;
            rf_reg_write  <= 1'b0;
        end else begin
            rf_reg_write <= accept && sel_commit;
            if (accept) begin
                if (sel_write) begin
                    rf_write_reg  <= sel_addr1;
                    rf_write_data <= sel_wdata;
                end else begin
                    rf_read_reg1 <= sel_addr1;
                    rf_read_reg2 <= sel_addr2;
                end
            end
        end
    end

    // Response data: captured in CAPTURE for reads, zeroed in ACCESS for writes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_data1 <= '0;
            rsp_data2 <= '0;
        end else if (state_q == StCapture) begin
            rsp_data1 <= rd1;
            rsp_data2 <= rd2;
        end else if ((state_q == StAccess) && cmd_write_q) begin
            rsp_data1 <= '0;
            rsp_data2 <= '0;
        end
    end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb_regfile_port_arbiter: directed stimulus with a response scoreboard for
// regfile_port_arbiter, plus a behavioural register_memory (registered reads).
module tb_regfile_port_arbiter;

    logic        clk;
    logic        reset_n;
    logic        c_req_valid, c_req_ready, c_req_write, c_rsp_valid, c_rsp_ready;
    logic [4:0]  c_req_addr1, c_req_addr2;
    logic [63:0] c_req_wdata;
    logic        d_req_valid, d_req_ready, d_req_write, d_rsp_valid, d_rsp_ready;
    logic [4:0]  d_req_addr1, d_req_addr2;
    logic [63:0] d_req_wdata;
    logic [63:0] rsp_data1, rsp_data2;
    logic [4:0]  rf_read_reg1, rf_read_reg2, rf_write_reg;
    logic [63:0] rf_write_data;
    logic        rf_reg_write;
    logic [63:0] rf_read_data1, rf_read_data2;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        bit          owner;
        logic [63:0] d1;
        logic [63:0] d2;
    } exp_t;
    exp_t sb[$];
    bit   grant_log[$];

    logic [63:0] mem [32];
    logic        preload;

    regfile_port_arbiter dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .c_req_valid   (c_req_valid),
        .c_req_ready   (c_req_ready),
        .c_req_write   (c_req_write),
        .c_req_addr1   (c_req_addr1),
        .c_req_addr2   (c_req_addr2),
        .c_req_wdata   (c_req_wdata),
        .c_rsp_valid   (c_rsp_valid),
        .c_rsp_ready   (c_rsp_ready),
        .d_req_valid   (d_req_valid),
        .d_req_ready   (d_req_ready),
        .d_req_write   (d_req_write),
        .d_req_addr1   (d_req_addr1),
        .d_req_addr2   (d_req_addr2),
        .d_req_wdata   (d_req_wdata),
        .d_rsp_valid   (d_rsp_valid),
        .d_rsp_ready   (d_rsp_ready),
        .rsp_data1     (rsp_data1),
        .rsp_data2     (rsp_data2),
        .rf_read_reg1  (rf_read_reg1),
        .rf_read_reg2  (rf_read_reg2),
        .rf_write_reg  (rf_write_reg),
        .rf_write_data (rf_write_data),
        .rf_reg_write  (rf_reg_write),
        .rf_read_data1 (rf_read_data1),
        .rf_read_data2 (rf_read_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] init_val(input int i);
        case (i)
            3:       return 64'h11;
            4:       return 64'h22;
            7:       return 64'h07;
            default: return 64'h0;
        endcase
    endfunction

    // Register file model: write on clock edge, registered read of the sampled addresses
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
        end else if (rf_reg_write) begin
            mem[rf_write_reg] <= rf_write_data;
        end
        rf_read_data1 <= mem[rf_read_reg1];
        rf_read_data2 <= mem[rf_read_reg2];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_rsp(input bit own);
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL rsp_unexpected: response for %0d with empty scoreboard", own);
        end else begin
            e = sb.pop_front();
            chk("rsp_owner", 64'(own), 64'(e.owner));
            chk("rsp_data1", rsp_data1, e.d1);
            chk("rsp_data2", rsp_data2, e.d2);
        end
    endtask

    // Monitor: pop and compare on every response handshake
    always @(negedge clk) begin
        if (reset_n) begin
            if (c_rsp_valid && c_rsp_ready) check_rsp(1'b0);
            if (d_rsp_valid && d_rsp_ready) check_rsp(1'b1);
        end
    end

    // Issue one request on requester own (0=C, 1=D); called #1 after a rising edge
    task automatic do_req(input bit own, input bit wr, input logic [4:0] a1,
                          input logic [4:0] a2, input logic [63:0] wd,
                          input logic [63:0] e1, input logic [63:0] e2,
                          input bit exp_we, input bit timing);
        int   n;
        exp_t e;
        if (own) begin
            d_req_valid = 1'b1; d_req_write = wr; d_req_addr1 = a1;
            d_req_addr2 = a2;   d_req_wdata = wd;
        end else begin
            c_req_valid = 1'b1; c_req_write = wr; c_req_addr1 = a1;
            c_req_addr2 = a2;   c_req_wdata = wd;
        end
        n = 0;
        @(negedge clk);
        while (!(own ? d_req_ready : c_req_ready)) begin
            n++;
            if (n > 60) begin
                vectors++;
                miscompares++;
                $display("FAIL grant_timeout: requester %0d never granted", own);
                if (own) d_req_valid = 1'b0; else c_req_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        if (own ? c_req_valid : d_req_valid)
            chk("ungranted_ready", 64'(own ? c_req_ready : d_req_ready), 64'd0);
        e.owner = own;
        e.d1    = e1;
        e.d2    = e2;
        sb.push_back(e);
        grant_log.push_back(own);
        @(posedge clk); #1;
        // Requester fields are don't-care once accepted
        if (own) begin
            d_req_valid = 1'b0; d_req_addr1 = 5'($urandom); d_req_wdata = 64'($urandom);
        end else begin
            c_req_valid = 1'b0; c_req_addr1 = 5'($urandom); c_req_wdata = 64'($urandom);
        end
        if (timing) begin
            chk("access_we", 64'(rf_reg_write), 64'(exp_we));
            if (wr) begin
                chk("access_wreg", 64'(rf_write_reg), 64'(a1));
                chk("access_wdata", rf_write_data, wd);
            end else begin
                chk("access_rreg1", 64'(rf_read_reg1), 64'(a1));
                chk("access_rreg2", 64'(rf_read_reg2), 64'(a2));
            end
            chk("access_rsp_valid", 64'(own ? d_rsp_valid : c_rsp_valid), 64'd0);
            @(posedge clk); #1;
            chk("we_one_cycle", 64'(rf_reg_write), 64'd0);
            chk("rsp_valid_n2", 64'(own ? d_rsp_valid : c_rsp_valid), 64'(wr));
            if (!wr) begin
                @(posedge clk); #1;
                chk("rsp_valid_n3", 64'(own ? d_rsp_valid : c_rsp_valid), 64'd1);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n = 1'b0; preload = 1'b1;
        c_req_valid = 0; c_req_write = 0; c_req_addr1 = 0; c_req_addr2 = 0; c_req_wdata = 0;
        d_req_valid = 0; d_req_write = 0; d_req_addr1 = 0; d_req_addr2 = 0; d_req_wdata = 0;
        c_rsp_ready = 1'b1; d_rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        c_req_valid = 1'b1; d_req_valid = 1'b1;
        #1;
        chk("rst_c_ready", 64'(c_req_ready), 64'd0);
        chk("rst_d_ready", 64'(d_req_ready), 64'd0);
        chk("rst_we", 64'(rf_reg_write), 64'd0);
        chk("rst_rreg1", 64'(rf_read_reg1), 64'd0);
        chk("rst_rreg2", 64'(rf_read_reg2), 64'd0);
        chk("rst_wreg", 64'(rf_write_reg), 64'd0);
        chk("rst_wdata", rf_write_data, 64'd0);
        chk("rst_rsp1", rsp_data1, 64'd0);
        chk("rst_rsp2", rsp_data2, 64'd0);
        chk("rst_c_rsp_valid", 64'(c_rsp_valid), 64'd0);
        chk("rst_d_rsp_valid", 64'(d_rsp_valid), 64'd0);
        c_req_valid = 1'b0; d_req_valid = 1'b0; preload = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Basic read, write, read-back
        do_req(1'b0, 1'b0, 5'd3, 5'd4, 64'd0, 64'h11, 64'h22, 1'b0, 1'b1);
        do_req(1'b0, 1'b1, 5'd5, 5'd0, 64'hDEAD, 64'd0, 64'd0, 1'b1, 1'b1);
        do_req(1'b0, 1'b0, 5'd5, 5'd3, 64'd0, 64'hDEAD, 64'h11, 1'b0, 1'b1);
        do_req(1'b1, 1'b0, 5'd4, 5'd5, 64'd0, 64'h22, 64'hDEAD, 1'b0, 1'b1);

        // Contention: last grant was D, so order must be C, D, C, D
        grant_log.delete();
        fork
            begin
                do_req(1'b0, 1'b0, 5'd3, 5'd4, 64'd0, 64'h11, 64'h22, 1'b0, 1'b1);
                do_req(1'b0, 1'b1, 5'd8, 5'd0, 64'h88, 64'd0, 64'd0, 1'b1, 1'b1);
            end
            begin
                do_req(1'b1, 1'b1, 5'd6, 5'd0, 64'h66, 64'd0, 64'd0, 1'b1, 1'b1);
                do_req(1'b1, 1'b0, 5'd6, 5'd8, 64'd0, 64'h66, 64'h88, 1'b0, 1'b1);
            end
        join
        chk("grant_count", 64'(grant_log.size()), 64'd4);
        if (grant_log.size() == 4) begin
            chk("grant_0", 64'(grant_log[0]), 64'd0);
            chk("grant_1", 64'(grant_log[1]), 64'd1);
            chk("grant_2", 64'(grant_log[2]), 64'd0);
            chk("grant_3", 64'(grant_log[3]), 64'd1);
        end

        // Response backpressure on C while D waits; d_rsp_ready high must be ignored
        c_rsp_ready = 1'b0;
        fork
            do_req(1'b0, 1'b0, 5'd5, 5'd6, 64'd0, 64'hDEAD, 64'h66, 1'b0, 1'b1);
            begin
                n = 0;
                @(negedge clk);
                while (!c_rsp_valid && n < 20) begin
                    n++;
                    @(negedge clk);
                end
                for (int i = 0; i < 5; i++) begin
                    chk("stall_valid", 64'(c_rsp_valid), 64'd1);
                    chk("stall_data1", rsp_data1, 64'hDEAD);
                    chk("stall_data2", rsp_data2, 64'h66);
                    chk("stall_d_ready", 64'(d_req_ready), 64'd0);
                    @(negedge clk);
                end
                @(posedge clk); #1;
                c_rsp_ready = 1'b1;
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                do_req(1'b1, 1'b0, 5'd3, 5'd3, 64'd0, 64'h11, 64'h11, 1'b0, 1'b1);
            end
        join
        repeat (4) @(posedge clk);
        #1;

        // Async reset during ACCESS of a write to X7: write must not commit
        c_req_valid = 1'b1; c_req_write = 1'b1; c_req_addr1 = 5'd7; c_req_wdata = 64'h77;
        n = 0;
        @(negedge clk);
        while (!c_req_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk); #1;
        c_req_valid = 1'b0;
        chk("rstmid_access_we", 64'(rf_reg_write), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rstmid_we", 64'(rf_reg_write), 64'd0);
        chk("rstmid_wreg", 64'(rf_write_reg), 64'd0);
        chk("rstmid_wdata", rf_write_data, 64'd0);
        chk("rstmid_rreg1", 64'(rf_read_reg1), 64'd0);
        chk("rstmid_rsp1", rsp_data1, 64'd0);
        chk("rstmid_c_rsp_valid", 64'(c_rsp_valid), 64'd0);
        chk("rstmid_c_ready", 64'(c_req_ready), 64'd0);
        @(posedge clk); #1;
        chk("rstmid_x7_kept", mem[7], 64'h07);
        reset_n = 1'b1;
        @(posedge clk); #1;
        do_req(1'b0, 1'b0, 5'd7, 5'd7, 64'd0, 64'h07, 64'h07, 1'b0, 1'b1);

        // Register 31
`ifdef RF_XZR_EN
        do_req(1'b1, 1'b1, 5'd31, 5'd0, 64'h5, 64'd0, 64'd0, 1'b0, 1'b1);
        do_req(1'b1, 1'b0, 5'd31, 5'd3, 64'd0, 64'd0, 64'h11, 1'b0, 1'b1);
`else
        do_req(1'b1, 1'b1, 5'd31, 5'd0, 64'h5, 64'd0, 64'd0, 1'b1, 1'b1);
        do_req(1'b1, 1'b0, 5'd31, 5'd3, 64'd0, 64'h5, 64'h11, 1'b0, 1'b1);
`endif

        repeat (5) @(posedge clk);
        #1;
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_port_arbiter.md
# regfile_port_arbiter

Sequencer and two-way arbiter for the `register_memory` register file. It shares that file's two read ports and one write port between the pipeline core (requester C) and the debug unit (requester D) using round-robin arbitration and valid/ready handshakes. It drives `register_memory` with `read_clk` and `write_clk` both tied to `clk`, and accounts for the file's one-cycle registered read latency. It returns read data or a write acknowledge to the requester that issued the transaction.

## Interface
Parameters:
- DATA_W, 64: register width (`WORD).
- ADDR_W, 5: register index width.

Ports (x ∈ {c, d}; each bullet describes one port per requester):
- clk  input  1  single clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- x_req_valid  input  1  request pending
- x_req_ready  output  1  request accepted this cycle
- x_req_write  input  1  1 = write, 0 = read
- x_req_addr1  input  ADDR_W  read register 1, or write register when x_req_write=1
- x_req_addr2  input  ADDR_W  read register 2 (ignored on writes)
- x_req_wdata  input  DATA_W  write data
- x_rsp_valid  output  1  response available for requester x
- x_rsp_ready  input  1  requester x consumes the response
- rsp_data1, rsp_data2  output  DATA_W  shared response data; 0 for writes
- rf_read_reg1, rf_read_reg2, rf_write_reg  output  ADDR_W  register-file addresses
- rf_write_data  output  DATA_W  register-file write data
- rf_reg_write  output  1  register-file write enable
- rf_read_data1, rf_read_data2  input  DATA_W  register-file read data, valid one cycle after the addresses are sampled

## Operation
- States:
  - IDLE: accept a request. Go to ACCESS.
  - ACCESS: drive the rf_* outputs for exactly one cycle. Go to CAPTURE on a read, RESP on a write.
  - CAPTURE: latch rf_read_data1/2 into rsp_data1/2. Go to RESP.
  - RESP: hold x_rsp_valid for the owning requester. Return to IDLE when x_rsp_ready=1.
- x_req_ready is high only in IDLE and only for the granted requester; it is combinational from state, both valids and last_grant.
- Arbitration:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester other than last_grant is granted.
  - last_grant updates on every accepted request.
- On accept, the arbiter latches write, addr1, addr2, wdata and the owner ID into command registers. Requester inputs are don't-care after that.
- rf_reg_write is 1 only in ACCESS of a write transaction. rf addresses and data hold their last values outside ACCESS.
- Only one transaction is in flight. Requests that are not granted wait with their valid held.

## Timing
- Reset values:
  - state = IDLE, last_grant = D, so C wins the first contention.
  - rf_read_reg1/2, rf_write_reg, rf_write_data, rf_reg_write = 0.
  - rsp_data1/2 = 0, both x_rsp_valid = 0.
  - x_req_ready = 0 while reset_n = 0.
- With the handshake on edge N:
  - Read: ACCESS in cycle N+1, CAPTURE in N+2, x_rsp_valid high from N+3.
  - Write: ACCESS in N+1, x_rsp_valid high from N+2.
- x_rsp_valid and rsp_data stay stable until x_rsp_ready is sampled high. The next request can be accepted in the cycle after the response handshake.
- Minimum transaction spacing: 4 cycles for a read, 3 for a write.
- x_rsp_ready on the non-owning requester is ignored.
- Reset asserted mid-transaction (async):
  - The outstanding transaction is dropped.
  - rf_reg_write falls immediately, so an ACCESS-cycle write is not committed.
  - Responses clear and state returns to IDLE.
- No read-after-write bypass is needed: transactions are serialized, so a read accepted after a write's response sees the new value.

## Configuration
- RF_XZR_EN defined: register 31 is XZR.
  - Writes to 31 keep rf_reg_write = 0 but are still acknowledged.
  - Reads return 0 on each rsp_data lane whose address is 31.
- RF_XZR_EN undefined: register 31 is an ordinary register.

## Test plan
- Preload X3=0x11, X4=0x22. C reads (3,4) → c_rsp_valid 3 cycles after accept, rsp_data1=0x11, rsp_data2=0x22.
- C writes X5=0xDEAD → rf_reg_write high exactly 1 cycle with rf_write_reg=5. c_rsp_valid 2 cycles after accept, rsp_data=0. A following read of X5 returns 0xDEAD.
- C and D hold valid for 4 transactions → grant order C, D, C, D. The ungranted x_req_ready stays 0.
- c_rsp_ready held low 5 cycles → c_rsp_valid and rsp_data stable, no request accepted, D waits.
- reset_n pulsed low during ACCESS of a write to X7 → rf_reg_write drops asynchronously, X7 unchanged, state IDLE, all outputs at reset values.
- With RF_XZR_EN: D writes X31=0x5 → ack, no rf_reg_write. D reads (31,3) → rsp_data1=0, rsp_data2=0x11.
